// File: rtl/bitsim_pkg.sv
// Shared types and constants for the bit-serial weight encoder.
package bitsim_pkg;

  localparam int unsigned GROUP_SIZE        = 8;
  localparam int unsigned SEL_W             = 4;
  localparam int unsigned MAX_SEL_PER_GROUP = 4;
  // Select value routed to the MAC mux zero input.
  localparam logic [SEL_W-1:0] SEL_ZERO     = 4'd8;

  // Four lane selects for one 8-lane group, entry 0 in the low nibble.
  typedef logic [MAX_SEL_PER_GROUP-1:0][SEL_W-1:0] group_sel_t;

  typedef enum logic {StIdle, StRun} enc_state_e;

endpackage

// File: rtl/group_col_encoder.sv
// Combinational encoder for one 8-lane group of one bit column.
// Selects the lane indices of the minority bit value; ties select ones.
module group_col_encoder
  import bitsim_pkg::*;
(
  input  logic [GROUP_SIZE-1:0] bits_i,
  output group_sel_t            sel_o,
  output logic                  skip_zero_o
);

  logic [3:0]            ones;
  logic [GROUP_SIZE-1:0] target;
  logic [2:0]            n_sel;

  // Popcount, pick the minority value, then pack matching lanes in ascending order.
  always_comb begin
    ones = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      ones = ones + {3'b000, bits_i[k]};
    end
    skip_zero_o = (ones <= 4'd4);
    target      = skip_zero_o ? bits_i : ~bits_i;
    sel_o       = {MAX_SEL_PER_GROUP{SEL_ZERO}};
    n_sel       = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (target[k] && (n_sel < 3'(MAX_SEL_PER_GROUP))) begin
        sel_o[n_sel[1:0]] = SEL_W'(k);
        n_sel             = n_sel + 3'd1;
      end
    end
  end

endmodule

// File: rtl/weight_col_encoder_16.sv
// Bit-serial weight-column encoder: latches one weight vector and emits one
// registered control word per bit column, LSB column first.
module weight_col_encoder_16
  import bitsim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  parameter int unsigned NUM_GROUP  = VEC_LENGTH / 8,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    w_valid,
  output logic                                    w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   w_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [VEC_LENGTH/2-1:0][SEL_WIDTH-1:0]  act_sel,
  output logic [NUM_GROUP-1:0]                    is_skip_zero,
  output logic [2:0]                              column_idx,
  output logic                                    is_msb,
  output logic                                    col_last
);

  localparam logic [2:0] LastCol = 3'(DATA_WIDTH - 1);

  enc_state_e                                  state_q, state_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]       w_q, w_d;
  logic                                        out_valid_q, out_valid_d;
  logic [VEC_LENGTH/2-1:0][SEL_WIDTH-1:0]      act_sel_q, act_sel_d;
  logic [NUM_GROUP-1:0]                        skip_q, skip_d;
  logic [2:0]                                  col_q, col_d;
  logic                                        msb_q, msb_d;

  logic                                        out_fire, last_fire, accept;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]       enc_w;
  logic [2:0]                                  enc_col;
  group_sel_t [NUM_GROUP-1:0]                  grp_sel;
  logic [NUM_GROUP-1:0]                        grp_skip;

  assign out_fire  = out_valid_q && out_ready;
  assign last_fire = out_fire && msb_q;
  assign w_ready   = (state_q == StIdle) || last_fire;
  assign accept    = w_valid && w_ready;

  // A new vector is encoded straight from w_in so column 0 lands one cycle after
  // the handshake; later columns come from the held weight register.
  assign enc_w   = accept ? w_in : w_q;
  assign enc_col = accept ? 3'd0 : col_q + 3'd1;

  for (genvar g = 0; g < NUM_GROUP; g++) begin : g_grp
    logic [GROUP_SIZE-1:0] bits;

    // Gather this group's bits of the column being encoded.
    always_comb begin
      for (int k = 0; k < GROUP_SIZE; k++) begin
        bits[k] = enc_w[g*GROUP_SIZE+k][enc_col];
      end
    end

    group_col_encoder u_enc (
      .bits_i      (bits),
      .sel_o       (grp_sel[g]),
      .skip_zero_o (grp_skip[g])
    );
  end

  // Next-state: accept a vector, advance a column, or drop back to idle values.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    act_sel_d   = act_sel_q;
    skip_d      = skip_q;
    col_d       = col_q;
    msb_d       = msb_q;
    if (accept) begin
      state_d     = StRun;
      w_d         = w_in;
      out_valid_d = 1'b1;
      col_d       = 3'd0;
      act_sel_d   = grp_sel;
      skip_d      = grp_skip;
      msb_d       = (LastCol == 3'd0);
    end else if (last_fire) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      col_d       = 3'd0;
      act_sel_d   = {(VEC_LENGTH/2){SEL_ZERO}};
      skip_d      = '1;
      msb_d       = 1'b0;
    end else if (out_fire) begin
      col_d     = enc_col;
      act_sel_d = grp_sel;
      skip_d    = grp_skip;
      msb_d     = (enc_col == LastCol);
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      act_sel_q   <= {(VEC_LENGTH/2){SEL_ZERO}};
      skip_q      <= '1;
      col_q       <= 3'd0;
      msb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      act_sel_q   <= act_sel_d;
      skip_q      <= skip_d;
      col_q       <= col_d;
      msb_q       <= msb_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign act_sel      = act_sel_q;
  assign is_skip_zero = skip_q;
  assign column_idx   = col_q;
  assign is_msb       = msb_q;
  assign col_last     = msb_q;

endmodule

// File: tb/tb_weight_col_encoder_16.sv
// Self-checking bench for weight_col_encoder_16: scoreboard of model words plus
// hand-computed literal checks on selected columns.
module tb_weight_col_encoder_16;

  typedef logic [15:0][7:0] vec_t;
  typedef struct {
    logic [31:0] sel;
    logic [1:0]  skip;
    logic [2:0]  col;
    logic        msb;
  } word_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            w_valid;
  logic            w_ready;
  vec_t            w_in;
  logic            out_valid;
  logic            out_ready;
  logic [7:0][3:0] act_sel;
  logic [1:0]      is_skip_zero;
  logic [2:0]      column_idx;
  logic            is_msb;
  logic            col_last;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    words_seen = 0;
  int    cyc = 0;
  word_t exp_q[$];
  word_t last_words[8];

  weight_col_encoder_16 dut (
    .clk          (clk),
    .reset        (reset),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_in         (w_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .act_sel      (act_sel),
    .is_skip_zero (is_skip_zero),
    .column_idx   (column_idx),
    .is_msb       (is_msb),
    .col_last     (col_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word from the rules: count ones per group, list lanes holding the
  // minority value (ones on a tie) in ascending order, pad with 8.
  function automatic word_t model(input vec_t w, input int c);
    word_t r;
    int ones, slot;
    logic want;
    r.sel  = 32'h8888_8888;
    r.skip = 2'b00;
    r.col  = 3'(c);
    r.msb  = (c == 7);
    for (int g = 0; g < 2; g++) begin
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(w[8*g+k][c]);
      want      = (ones <= 4);
      r.skip[g] = want;
      slot      = 0;
      for (int k = 0; k < 8; k++) begin
        if (w[8*g+k][c] == want && slot < 4) begin
          r.sel[(4*g+slot)*4 +: 4] = 4'(k);
          slot++;
        end
      end
    end
    return r;
  endfunction

  // Compare process: checks each consumed word against the scoreboard and
  // checks that a stalled word holds steady.
  initial begin
    word_t snap, cur, e;
    logic  prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      cur.sel  = act_sel;
      cur.skip = is_skip_zero;
      cur.col  = column_idx;
      cur.msb  = is_msb;
      if (out_valid) begin
        if (prev_stall) begin
          chk("hold_sel", cur.sel, snap.sel);
          chk("hold_skip", 32'(cur.skip), 32'(snap.skip));
          chk("hold_col", 32'(cur.col), 32'(snap.col));
          chk("hold_msb", 32'(cur.msb), 32'(snap.msb));
        end
        if (!out_ready) begin
          chk("stall_wready", 32'(w_ready), 32'd0);
          prev_stall = 1'b1;
          snap       = cur;
        end else begin
          prev_stall = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("act_sel", cur.sel, e.sel);
            chk("skip", 32'(cur.skip), 32'(e.skip));
            chk("column_idx", 32'(cur.col), 32'(e.col));
            chk("is_msb", 32'(cur.msb), 32'(e.msb));
            chk("col_last", 32'(col_last), 32'(e.msb));
          end
          last_words[cur.col] = cur;
          words_seen++;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (w_valid && w_ready) begin
        for (int c = 0; c < 8; c++) exp_q.push_back(model(w_in, c));
      end
    end
  end

  task automatic send(input vec_t w);
    int i;
    w_in    = w;
    w_valid = 1'b1;
    i       = 0;
    @(negedge clk);
    while (!w_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!w_ready) chk("send_timeout", 32'(w_ready), 32'd1);
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int i;
    i = 0;
    while (words_seen < target && i < 200) begin
      @(posedge clk);
      #1 i++;
    end
    if (words_seen < target) chk("word_timeout", 32'(words_seen), 32'(target));
  endtask

  task automatic wait_col(input logic [2:0] c);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1 i++;
    end while (!(out_valid && column_idx == c) && i < 50);
    if (!(out_valid && column_idx == c)) chk("col_timeout", 32'(column_idx), 32'(c));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_col"}, 32'(column_idx), 32'd0);
    chk({tag, "_msb"}, 32'(is_msb), 32'd0);
    chk({tag, "_last"}, 32'(col_last), 32'd0);
    chk({tag, "_sel"}, act_sel, 32'h8888_8888);
    chk({tag, "_skip"}, 32'(is_skip_zero), 32'd3);
    chk({tag, "_wready"}, 32'(w_ready), 32'd1);
  endtask

  initial begin
    vec_t v, va, vb;
    int   base, c0, c1;
    reset     = 1'b1;
    w_valid   = 1'b0;
    out_ready = 1'b1;
    w_in      = '0;
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: all zero weights.
    v = '0;
    base = words_seen;
    send(v);
    wait_until(base + 8);
    chk("t1_c0_sel", last_words[0].sel, 32'h8888_8888);
    chk("t1_c3_skip", 32'(last_words[3].skip), 32'd3);
    chk("t1_c6_msb", 32'(last_words[6].msb), 32'd0);
    chk("t1_c7_msb", 32'(last_words[7].msb), 32'd1);

    // 2: all weights 1.
    for (int k = 0; k < 16; k++) v[k] = 8'h01;
    base = words_seen;
    send(v);
    wait_until(base + 8);
    chk("t2_c0_skip", 32'(last_words[0].skip), 32'd0);
    chk("t2_c0_sel", last_words[0].sel, 32'h8888_8888);
    chk("t2_c1_skip", 32'(last_words[1].skip), 32'd3);
    chk("t2_c5_sel", last_words[5].sel, 32'h8888_8888);

    // 3: single MSB in lane 3.
    v = '0;
    v[3] = 8'h80;
    base = words_seen;
    send(v);
    wait_until(base + 8);
    chk("t3_c7_sel", last_words[7].sel, 32'h8888_8883);
    chk("t3_c7_msb", 32'(last_words[7].msb), 32'd1);
    chk("t3_c0_sel", last_words[0].sel, 32'h8888_8888);

    // 4: lanes 8..12 = 4, so group 1 column 2 has five ones.
    v = '0;
    for (int k = 8; k <= 12; k++) v[k] = 8'h04;
    base = words_seen;
    send(v);
    wait_until(base + 8);
    chk("t4_c2_sel", last_words[2].sel, 32'h8765_8888);
    chk("t4_c2_skip", 32'(last_words[2].skip), 32'd1);
    chk("t4_c1_sel", last_words[1].sel, 32'h8888_8888);

    // 5a: stall at column 3 for five cycles.
    for (int k = 0; k < 16; k++) v[k] = 8'(8'h5A ^ (k * 8'h13));
    base = words_seen;
    send(v);
    wait_col(3'd3);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_col", 32'(column_idx), 32'd3);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_wready_drv", 32'(w_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_until(base + 8);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // 5b: two vectors back to back must give 16 words in 16 cycles.
    for (int k = 0; k < 16; k++) begin
      va[k] = 8'(k * 8'h1D + 8'h07);
      vb[k] = 8'(8'hF0 - k * 8'h0B);
    end
    base = words_seen;
    send(va);
    c0 = cyc;
    send(vb);
    wait_until(base + 16);
    c1 = cyc;
    chk("b2b_cycles", 32'(c1 - c0), 32'd16);

    // 6: reset at column 4 drops the vector.
    for (int k = 0; k < 16; k++) v[k] = 8'(8'hC3 + k);
    send(v);
    wait_col(3'd4);
    reset = 1'b1;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    chk("midrst_valid2", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_wready", 32'(w_ready), 32'd1);
    chk("rel_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
